// File: rtl/mem_arbiter2_if.sv
// mem_arbiter2_if: bundle of the two requester ports and the shared memory
// port handled by mem_arbiter2.
//
// Handshake: a master raises reqX and holds addrX/wdataX/weX stable. The
// arbiter answers with gntX (one-hot or zero) while the shared port carries
// the access (mem_valid=1). The memory completes it by raising mem_ready in
// any granted cycle. doneX pulses for exactly that cycle. If mem_ready never
// comes, doneX and err pulse together in the last allowed cycle.
//
// Modports:
//   slave  - arbiter side: takes requests and mem_ready, drives the shared
//            port, the grants, the done/err pulses and dbg_state.
//   master - environment side: the two masters plus the memory.
interface mem_arbiter2_if #(
  parameter int n = 16
);
  logic         req0;
  logic         req1;
  logic [n-1:0] addr0;
  logic [n-1:0] addr1;
  logic [n-1:0] wdata0;
  logic [n-1:0] wdata1;
  logic         we0;
  logic         we1;
  logic         mem_ready;
  logic         mem_valid;
  logic [n-1:0] mem_addr;
  logic [n-1:0] mem_wdata;
  logic         mem_we;
  logic         sel;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic         err;
  logic [1:0]   dbg_state;

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ready,
    output mem_valid, mem_addr, mem_wdata, mem_we, sel,
           gnt0, gnt1, done0, done1, err, dbg_state
  );

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ready,
    input  mem_valid, mem_addr, mem_wdata, mem_we, sel,
           gnt0, gnt1, done0, done1, err, dbg_state
  );
endinterface

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-requester round-robin arbiter sharing one n-bit memory
// port. Grants one master at a time, drives the shared-port mux select, and
// aborts an access the memory does not finish within TIMEOUT cycles.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - mem_arbiter2_if.slave (requests, shared port, grants,
//            done/err pulses, dbg_state = current FSM state)
module mem_arbiter2 #(
  parameter int n       = 16,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter2_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;

  // Value of cnt in the TIMEOUT-th granted cycle (cnt starts at 0).
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       sel;
  logic       last;
  logic [7:0] cnt;

  logic       busy;
  logic       complete;
  logic       timeout;
  logic       grant;
  logic       grant_idx;

  logic [n-1:0] addr_mux;
  logic [n-1:0] wdata_mux;

  assign busy     = (state != IDLE);
  assign timeout  = busy && !bus.mem_ready && (cnt == CNT_LAST);
  // mem_ready in the final cycle wins over the timeout.
  assign complete = busy && (bus.mem_ready || (cnt == CNT_LAST));

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_idx = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          grant     = 1'b1;
          grant_idx = ~last;
        end else if (bus.req0) begin
          grant     = 1'b1;
          grant_idx = 1'b0;
        end else if (bus.req1) begin
          grant     = 1'b1;
          grant_idx = 1'b1;
        end
      end
      BUSY0: begin
        // Only the other master may be granted straight away; a repeat
        // request from the same master goes through IDLE.
        if (complete) begin
          if (bus.req1) begin
            grant     = 1'b1;
            grant_idx = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      BUSY1: begin
        if (complete) begin
          if (bus.req0) begin
            grant     = 1'b1;
            grant_idx = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) begin
      state_nxt = grant_idx ? BUSY1 : BUSY0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        sel  <= grant_idx;
        last <= grant_idx;
        cnt  <= 8'd0;
      end else if (busy && !bus.mem_ready) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Shared-port muxes follow the registered select only.
  assign addr_mux  = sel ? bus.addr1  : bus.addr0;
  assign wdata_mux = sel ? bus.wdata1 : bus.wdata0;

  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_valid = busy;
  assign bus.mem_we    = busy && (sel ? bus.we1 : bus.we0);
  assign bus.sel       = sel;
  assign bus.gnt0      = (state == BUSY0);
  assign bus.gnt1      = (state == BUSY1);
  assign bus.done0     = (state == BUSY0) && complete;
  assign bus.done1     = (state == BUSY1) && complete;
  assign bus.err       = timeout;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: directed bench for mem_arbiter2 with TIMEOUT = 4.
module tb_mem_arbiter2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY0 = 2'd1;
  localparam logic [1:0] S_BUSY1 = 2'd2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_arbiter2_if #(.n(16)) bus ();

  mem_arbiter2 #(.n(16), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.req0      = 1'b0;
    bus.req1      = 1'b0;
    bus.addr0     = 16'h0000;
    bus.addr1     = 16'h0000;
    bus.wdata0    = 16'h0000;
    bus.wdata1    = 16'h0000;
    bus.we0       = 1'b0;
    bus.we1       = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    chk("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_valid", 32'(bus.mem_valid), 0);
    chk("rst_sel", 32'(bus.sel), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_done0", 32'(bus.done0), 0);
    chk("rst_done1", 32'(bus.done1), 0);
    chk("rst_err", 32'(bus.err), 0);
    #10;
    rst_n = 1'b1;

    // Reset mid-access
    bus.req1 = 1'b1;
    cyc();
    chk("mid_gnt1", 32'(bus.gnt1), 1);
    chk("mid_sel1", 32'(bus.sel), 1);
    bus.req1      = 1'b0;
    bus.mem_ready = 1'b1;
    settle();
    chk("mid_done1_pre", 32'(bus.done1), 1);
    rst_n = 1'b0;
    settle();
    chk("mid_rst_gnt1", 32'(bus.gnt1), 0);
    chk("mid_rst_valid", 32'(bus.mem_valid), 0);
    chk("mid_rst_sel", 32'(bus.sel), 0);
    chk("mid_rst_done1", 32'(bus.done1), 0);
    chk("mid_rst_err", 32'(bus.err), 0);
    cyc();
    chk("mid_rst_hold", 32'(bus.mem_valid), 0);
    rst_n         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.req0      = 1'b1;
    cyc();
    chk("mid_after_gnt0", 32'(bus.gnt0), 1);
    chk("mid_after_sel0", 32'(bus.sel), 0);
    bus.mem_ready = 1'b1;
    bus.req0      = 1'b0;
    settle();
    chk("mid_after_done0", 32'(bus.done0), 1);
    cyc();
    chk("mid_after_idle", 32'(bus.dbg_state), 32'(S_IDLE));
    bus.mem_ready = 1'b0;

    // Single read, mem_ready on the 3rd granted cycle
    bus.req0  = 1'b1;
    bus.addr0 = 16'h0040;
    bus.we0   = 1'b0;
    settle();
    chk("rd_no_gnt_yet", 32'(bus.gnt0), 0);
    cyc();
    chk("rd_gnt0", 32'(bus.gnt0), 1);
    chk("rd_addr", 32'(bus.mem_addr), 32'h0040);
    chk("rd_we", 32'(bus.mem_we), 0);
    chk("rd_done_c1", 32'(bus.done0), 0);
    cyc();
    chk("rd_done_c2", 32'(bus.done0), 0);
    chk("rd_gnt_c2", 32'(bus.gnt0), 1);
    cyc();
    bus.mem_ready = 1'b1;
    settle();
    chk("rd_done_c3", 32'(bus.done0), 1);
    chk("rd_err_c3", 32'(bus.err), 0);
    bus.req0 = 1'b0;
    cyc();
    bus.mem_ready = 1'b0;
    settle();
    chk("rd_idle_valid", 32'(bus.mem_valid), 0);
    chk("rd_idle_done", 32'(bus.done0), 0);

    // Tie from reset: alternation 0,1,0,1 with no bubble
    rst_n = 1'b0;
    settle();
    rst_n         = 1'b1;
    bus.addr0     = 16'h0A0A;
    bus.addr1     = 16'h0B0B;
    bus.req0      = 1'b1;
    bus.req1      = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("tie_valid", 32'(bus.mem_valid), 1);
      chk("tie_gnt0", 32'(bus.gnt0), (i % 2 == 0) ? 1 : 0);
      chk("tie_gnt1", 32'(bus.gnt1), (i % 2 == 1) ? 1 : 0);
      chk("tie_sel", 32'(bus.sel), (i % 2 == 1) ? 1 : 0);
      chk("tie_addr", 32'(bus.mem_addr), (i % 2 == 0) ? 32'h0A0A : 32'h0B0B);
      chk("tie_done", 32'({bus.done1, bus.done0}), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    cyc();
    bus.mem_ready = 1'b0;
    settle();
    chk("tie_end_idle", 32'(bus.mem_valid), 0);

    // Write muxing through master 1
    bus.req1   = 1'b1;
    bus.addr1  = 16'h1234;
    bus.wdata1 = 16'hBEEF;
    bus.we1    = 1'b1;
    bus.addr0  = 16'hFFFF;
    bus.wdata0 = 16'h0000;
    bus.we0    = 1'b1;
    cyc();
    chk("wr_gnt1", 32'(bus.gnt1), 1);
    chk("wr_addr", 32'(bus.mem_addr), 32'h1234);
    chk("wr_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    chk("wr_we", 32'(bus.mem_we), 1);
    bus.mem_ready = 1'b1;
    bus.req1      = 1'b0;
    settle();
    chk("wr_done1", 32'(bus.done1), 1);
    cyc();
    bus.mem_ready = 1'b0;
    settle();
    chk("wr_idle_we", 32'(bus.mem_we), 0);
    chk("wr_idle_valid", 32'(bus.mem_valid), 0);
    chk("wr_idle_sel_hold", 32'(bus.sel), 1);
    bus.we0 = 1'b0;
    bus.we1 = 1'b0;

    // Timeout: no mem_ready for 4 cycles
    bus.req0 = 1'b1;
    cyc();
    bus.req0 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("to_gnt", 32'(bus.gnt0), 1);
      chk("to_done_early", 32'(bus.done0), 0);
      chk("to_err_early", 32'(bus.err), 0);
      cyc();
    end
    chk("to_gnt_c4", 32'(bus.gnt0), 1);
    chk("to_done_c4", 32'(bus.done0), 1);
    chk("to_err_c4", 32'(bus.err), 1);
    cyc();
    chk("to_idle", 32'(bus.dbg_state), 32'(S_IDLE));
    chk("to_err_cleared", 32'(bus.err), 0);

    // Timeout boundary: mem_ready arrives in the 4th cycle
    bus.req0 = 1'b1;
    cyc();
    bus.req0 = 1'b0;
    cyc();
    cyc();
    chk("tb_state_c3", 32'(bus.dbg_state), 32'(S_BUSY0));
    cyc();
    bus.mem_ready = 1'b1;
    settle();
    chk("tb_done_c4", 32'(bus.done0), 1);
    chk("tb_err_c4", 32'(bus.err), 0);
    cyc();
    bus.mem_ready = 1'b0;
    settle();
    chk("tb_idle", 32'(bus.mem_valid), 0);

    // Same-master re-request: exactly one bubble
    bus.req0      = 1'b1;
    bus.mem_ready = 1'b1;
    cyc();
    chk("rr_gnt_a", 32'(bus.gnt0), 1);
    chk("rr_done_a", 32'(bus.done0), 1);
    cyc();
    chk("rr_bubble_valid", 32'(bus.mem_valid), 0);
    chk("rr_bubble_gnt", 32'(bus.gnt0), 0);
    cyc();
    chk("rr_gnt_b", 32'(bus.gnt0), 1);
    chk("rr_done_b", 32'(bus.done0), 1);
    chk("rr_state_b", 32'(bus.dbg_state), 32'(S_BUSY0));
    bus.req0 = 1'b0;
    cyc();
    bus.mem_ready = 1'b0;
    settle();
    chk("rr_end_idle", 32'(bus.dbg_state), 32'(S_IDLE));
    chk("rr_end_gnt1", 32'(bus.gnt1), 0);

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-requester round-robin arbiter that shares one n-bit memory port between two masters, e.g. instruction fetch (port 0) and data load/store (port 1) in the multicycle CPU. It owns the select line of the shared-port 2:1 multiplexers (mux2 instances for address, write data and write enable). It sequences each access as a request/grant/done handshake and aborts any access the memory fails to complete within a bounded number of cycles.

## Interface
- `n`, 16: address and data width of the shared port.
- `TIMEOUT`, 15: maximum cycles a grant is held without `mem_ready`; legal range 2..255.

- `clk`  in  1  system clock, rising edge active.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  access request from master 0 and master 1.
- `addr0`, `addr1`  in  n  access address; held stable by the master while its request is pending or granted.
- `wdata0`, `wdata1`  in  n  write data; held stable by the master under the same rule as the address.
- `we0`, `we1`  in  1  write enable; 1 = write, 0 = read.
- `mem_ready`  in  1  memory completes the presented access this cycle.
- `mem_valid`  out  1  shared port carries a valid access.
- `mem_addr`, `mem_wdata`  out  n  muxed address and write data; equal to `sel ? *1 : *0`.
- `mem_we`  out  1  muxed write enable, gated by `mem_valid`.
- `sel`  out  1  registered mux select; the index of the last-granted master.
- `gnt0`, `gnt1`  out  1  grant, one-hot or zero.
- `done0`, `done1`  out  1  single-cycle completion pulse to the granted master.
- `err`  out  1  single-cycle timeout pulse, coincident with the `done` being aborted.

## Operation
- States:
  - IDLE: no grant.
  - BUSY0: master 0 granted.
  - BUSY1: master 1 granted.
- Output decode:
  - `gnt0` = (state == BUSY0) and `gnt1` = (state == BUSY1).
  - `mem_valid` = (state != IDLE).
  - `mem_we` = `mem_valid` & (`sel` ? `we1` : `we0`).
- Registered state:
  - `last` is 1 bit. It records the master most recently granted and is updated on every grant.
  - `cnt` is an 8-bit cycle counter. It is cleared on every grant and increments each BUSY cycle in which `mem_ready` = 0.
- IDLE transitions:
  - Only one of `req0`/`req1` high: go to BUSYx for that master.
  - Both high: grant the master != `last` (round-robin).
  - Neither high: stay in IDLE.
  - On any grant: `sel` ← granted index, `last` ← granted index, `cnt` ← 0.
- Completion in BUSYx:
  - Normal completion: `mem_ready` = 1 → `donex` = 1 (combinational, same cycle).
  - Timeout: `mem_ready` = 0 and `cnt` == TIMEOUT-1 → `donex` = 1 and `err` = 1.
- On completion or timeout:
  - Other master's request high: go directly to BUSY(other), updating `sel`, `last` and `cnt` (zero bubble).
  - Otherwise: go to IDLE. The same master's held request is re-granted from IDLE, so there is a minimum one-cycle bubble.
- `req` deasserted while granted: ignored. The access runs until `mem_ready` or timeout.
- Masters must not change `addr`/`wdata`/`we` between grant and `done`.
- `sel` holds its value in IDLE and never glitches. `mem_*` muxing follows `sel` only.

## Timing
- Reset values:
  - state = IDLE, `sel` = 0, `last` = 1 (master 0 wins the first tie), `cnt` = 0.
  - All `gnt`, `done`, `err` and `mem_valid` = 0.
  - `mem_we` = 0.
- Reset is asynchronous and mid-access: the access is abandoned immediately and no `done` or `err` is issued.
- Grant latency: a request sampled high at edge k in IDLE gives `gnt`/`mem_valid` high after edge k.
- Fastest access: 1 BUSY cycle when `mem_ready` is high in the first granted cycle.
- Timeout: a grant lasts at most TIMEOUT cycles. `err` fires in the TIMEOUT-th cycle.
  - `mem_ready` = 1 in that cycle counts as normal completion, with `err` = 0.
- Back-to-back alternation: with both masters requesting continuously, grants alternate 0,1,0,1 with no IDLE cycles.

## Test plan
- Reset mid-access: grant master 1, assert `rst_n` = 0 for 1 cycle.
  - Expect immediately `gnt1` = 0, `mem_valid` = 0, `sel` = 0, no `done1`.
  - Then `req0` = 1 → `gnt0` next cycle.
- Single read: `req0` = 1, `addr0` = 0x0040, `we0` = 0; `mem_ready` = 1 on the 3rd granted cycle.
  - Expect `gnt0` one cycle after `req0`, `mem_addr` = 0x0040, `mem_we` = 0.
  - Expect `done0` for exactly 1 cycle, then IDLE.
- Tie from reset: `req0` = `req1` = 1 simultaneously; memory accepts every cycle.
  - Expect grant order 0,1,0,1 with `sel` following.
  - Expect `mem_addr` alternating `addr0`/`addr1` and no IDLE cycles.
- Write muxing: `req1` = 1, `addr1` = 0x1234, `wdata1` = 0xBEEF, `we1` = 1, while `we0` = 1, `addr0` = 0xFFFF.
  - Expect `mem_addr` = 0x1234, `mem_wdata` = 0xBEEF, `mem_we` = 1.
  - Expect `mem_we` = 0 once back in IDLE.
- Timeout: TIMEOUT = 4, `req0` = 1, `mem_ready` held 0.
  - Expect `done0` = `err` = 1 in the 4th granted cycle, then IDLE.
  - Repeat with `mem_ready` = 1 in the 4th cycle → `done0` = 1, `err` = 0.
- Same-master re-request: `req0` held high across 2 accesses, `req1` = 0.
  - Expect exactly 1 IDLE cycle (`mem_valid` = 0) between `done0` and the next `gnt0`.
